// File: rtl/intctl.sv
// Interrupt controller for the cpu68 bus: per-source pending latches, edge/level mode,
// mask, global enable and a priority vector. Optional tick timer on source 7: INTCTL_TIMER_EN.
module intctl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq
);

  logic            wr;
  logic            rd;
  logic [NSRC-1:0] src_in;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] src_p;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pend_nx;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] set_v;
  logic [NSRC-1:0] clr_v;
  logic            gie;
  logic            active;
  logic [2:0]      idx;

  assign wr = cs && !rw;
  assign rd = cs && rw;

`ifdef INTCTL_TIMER_EN
  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic [15:0] reload;
  logic [15:0] cnt;
  logic        tick;

  assign reload = {reload_hi, reload_lo};
  assign tick   = (reload != 16'd0) && (cnt == 16'd0);
  assign src_in = {tick, irq_src[NSRC-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      cnt       <= 16'd0;
    end else begin
      if (wr && AD == 3'd6)
        reload_lo <= DI;
      // Writing the high byte also restarts the count from the new reload value.
      if (wr && AD == 3'd7) begin
        reload_hi <= DI;
        cnt       <= {DI, reload_lo};
      end else if (reload != 16'd0) begin
        cnt <= (cnt == 16'd0) ? reload : cnt - 16'd1;
      end
    end
  end
`else
  assign src_in = irq_src;
`endif

  always_comb begin
    act    = pending & mask;
    active = |act;
    idx    = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (act[i]) idx = 3'(i);
  end

  // Set beats clear; level-mode bits simply track the synchronised input.
  always_comb begin
    set_v = src_q & ~src_p;
    if (wr && AD == 3'd4)
      set_v = set_v | DI;
    clr_v = '0;
    if (wr && AD == 3'd0)
      clr_v = DI;
    if (rd && AD == 3'd3 && active)
      clr_v[idx] = 1'b1;
    for (int i = 0; i < NSRC; i++)
      pend_nx[i] = mode[i] ? (set_v[i] | (pending[i] & ~clr_v[i])) : src_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      src_p   <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      gie     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      src_q   <= src_in;
      src_p   <= src_q;
      pending <= pend_nx;
      irq     <= gie && active;
      if (wr) begin
        case (AD)
          3'd1:    mask <= DI;
          3'd2:    mode <= DI;
          3'd5:    gie  <= DI[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    DO = 8'hFF;
    case (AD)
      3'd0: DO = pending;
      3'd1: DO = mask;
      3'd2: DO = mode;
      3'd3: DO = {active, 4'b0000, idx};
      3'd4: DO = 8'h00;
      3'd5: DO = {7'b0000000, gie};
`ifdef INTCTL_TIMER_EN
      3'd6: DO = reload_lo;
      3'd7: DO = reload_hi;
`endif
      default: DO = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_intctl.sv
// Directed self-checking bench for intctl.
module tb_intctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic [7:0] irq_src = 8'h00;
  logic       irq;

  int checks = 0;
  int failures = 0;

  intctl dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    AD = a; rw = 1'b1; cs = 1'b1;
    #1;
    d = DO;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b0; AD = a;
    #1;
    d = DO;
  endtask

  task automatic do_reset();
    irq_src = 8'h00; cs = 1'b0; rw = 1'b1; rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", v); end
    peek(3'd1, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", v); end
    peek(3'd2, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_mode got=%h exp=00", v); end
    peek(3'd5, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_write(3'd5, 8'h01);
    irq_src = 8'hFF;
    tick_n(2);
    peek(3'd0, v); checks++; if (v !== 8'hFF) begin failures++; $display("FAIL masked_pend got=%h exp=ff", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq got=%b exp=0", irq); end
    irq_src = 8'h00;
    tick_n(3);
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL level_drop_pend got=%h exp=00", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq_late got=%b exp=0", irq); end
  endtask

  task automatic test_regs();
    logic [7:0] v;
    do_reset();
    bus_write(3'd1, 8'hA5); bus_read(3'd1, v);
    checks++; if (v !== 8'hA5) begin failures++; $display("FAIL mask_rb got=%h exp=a5", v); end
    bus_write(3'd2, 8'h3C); bus_read(3'd2, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL mode_rb got=%h exp=3c", v); end
    bus_write(3'd5, 8'hFF); bus_read(3'd5, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL ctrl_rb got=%h exp=01", v); end
    bus_read(3'd4, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL set_rd got=%h exp=00", v); end
`ifndef INTCTL_TIMER_EN
    bus_write(3'd6, 8'h12); bus_read(3'd6, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL ad6_rd got=%h exp=ff", v); end
    bus_read(3'd7, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL ad7_rd got=%h exp=ff", v); end
`endif
    // Level-mode bits ignore SET.
    bus_write(3'd2, 8'h00);
    bus_write(3'd4, 8'hFF);
    tick_n(1);
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL level_set got=%h exp=00", v); end
  endtask

  task automatic test_edge_single();
    logic [7:0] v;
    do_reset();
    bus_write(3'd2, 8'hFF); bus_write(3'd1, 8'h04); bus_write(3'd5, 8'h01);
    irq_src = 8'h04;
    tick_n(1);
    irq_src = 8'h00;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_e1_irq got=%b exp=0", irq); end
    tick_n(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_e2_irq got=%b exp=0", irq); end
    tick_n(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_e3_irq got=%b exp=1", irq); end
    bus_read(3'd3, v);
    checks++; if (v !== 8'h82) begin failures++; $display("FAIL edge_vect1 got=%h exp=82", v); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_clr_c_irq got=%b exp=1", irq); end
    bus_read(3'd3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL edge_vect2 got=%h exp=00", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_clr_c1_irq got=%b exp=0", irq); end
  endtask

  task automatic test_level();
    logic [7:0] v;
    do_reset();
    bus_write(3'd1, 8'h01); bus_write(3'd5, 8'h01);
    irq_src = 8'h01;
    tick_n(3);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq got=%b exp=1", irq); end
    bus_write(3'd0, 8'h01);
    tick_n(1);
    peek(3'd0, v); checks++; if (v !== 8'h01) begin failures++; $display("FAIL level_w1c got=%h exp=01", v); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_w1c_irq got=%b exp=1", irq); end
    irq_src = 8'h00;
    tick_n(2);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_drop_e2 got=%b exp=1", irq); end
    tick_n(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_drop_e3 got=%b exp=0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    do_reset();
    bus_write(3'd2, 8'hFF); bus_write(3'd1, 8'hFF); bus_write(3'd5, 8'h01);
    irq_src = 8'h22;
    tick_n(1);
    irq_src = 8'h00;
    tick_n(2);
    bus_read(3'd3, v);
    checks++; if (v !== 8'h81) begin failures++; $display("FAIL b2b_vect1 got=%h exp=81", v); end
    bus_read(3'd3, v);
    checks++; if (v !== 8'h85) begin failures++; $display("FAIL b2b_vect2 got=%h exp=85", v); end
    bus_read(3'd3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL b2b_vect3 got=%h exp=00", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL b2b_irq got=%b exp=0", irq); end
  endtask

  task automatic test_set_wins(input logic [7:0] ctrl);
    logic [7:0] v;
    do_reset();
    bus_write(3'd2, 8'hFF); bus_write(3'd1, 8'h08); bus_write(3'd5, ctrl);
    irq_src = 8'h08;
    bus_write(3'd4, 8'h08);
    bus_write(3'd0, 8'h08);
    peek(3'd0, v); checks++; if (v !== 8'h08) begin failures++; $display("FAIL set_wins gie=%0d got=%h exp=08", ctrl[0], v); end
    tick_n(2);
    checks++; if (irq !== ctrl[0]) begin failures++; $display("FAIL set_wins_irq gie=%0d got=%b exp=%b", ctrl[0], irq, ctrl[0]); end
    bus_write(3'd0, 8'h08);
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL w1c_clear gie=%0d got=%h exp=00", ctrl[0], v); end
    irq_src = 8'h00;
    tick_n(2);
  endtask

  task automatic test_mode_switch();
    logic [7:0] v;
    do_reset();
    irq_src = 8'h10;
    tick_n(3);
    bus_write(3'd2, 8'h10);
    irq_src = 8'h00;
    tick_n(3);
    peek(3'd0, v); checks++; if (v !== 8'h10) begin failures++; $display("FAIL mode_retain got=%h exp=10", v); end
    bus_write(3'd2, 8'h00);
    tick_n(1);
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL mode_to_level got=%h exp=00", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    bus_write(3'd2, 8'hFF); bus_write(3'd1, 8'hFF); bus_write(3'd5, 8'h01);
    bus_write(3'd4, 8'hFF);
    tick_n(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_pre_irq got=%b exp=1", irq); end
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_pend got=%h exp=00", v); end
    peek(3'd1, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_mask got=%h exp=00", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=0", irq); end
  endtask

`ifdef INTCTL_TIMER_EN
  task automatic test_timer();
    logic [7:0] v;
    int cyc = 0;
    int n1 = -1;
    int n2 = -1;
    do_reset();
    bus_write(3'd6, 8'h09); bus_write(3'd7, 8'h00);
    bus_write(3'd2, 8'h80); bus_write(3'd1, 8'h80); bus_write(3'd5, 8'h01);
    for (int k = 0; k < 40 && n1 < 0; k++) begin
      tick_n(1); cyc++;
      peek(3'd0, v);
      if (v[7]) n1 = cyc;
    end
    checks++; if (n1 < 0) begin failures++; $display("FAIL timer_first_tick got=none exp=tick"); end
    bus_read(3'd3, v); cyc++;
    checks++; if (v !== 8'h87) begin failures++; $display("FAIL timer_vect got=%h exp=87", v); end
    for (int k = 0; k < 40 && n2 < 0; k++) begin
      tick_n(1); cyc++;
      peek(3'd0, v);
      if (v[7]) n2 = cyc;
    end
    checks++; if (n1 < 0 || n2 < 0 || n2 - n1 != 10) begin failures++; $display("FAIL timer_period got=%0d exp=10", n2 - n1); end
    bus_write(3'd6, 8'h00); bus_write(3'd7, 8'h00);
    tick_n(3);
    bus_write(3'd0, 8'h80);
    tick_n(30);
    peek(3'd0, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL timer_halt got=%h exp=00", v); end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_edge_single();
    test_level();
    test_back_to_back();
    test_set_wins(8'h01);
    test_set_wins(8'h00);
    test_mode_switch();
    test_reset_mid();
`ifdef INTCTL_TIMER_EN
    test_timer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
